// File: rtl/nand_n_filt_if.sv
// nand_n_filt service-cell bus
// logic inputs, ATE controls and filtered outputs
interface nand_n_filt_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] mask;
  logic             force_en;
  logic             force_val;
  logic             cnt_clr;
  logic             o;
  logic             busy;
  logic [CNT_W-1:0] toggles;

  modport master (
    output i, mask, force_en,
    output force_val, cnt_clr,
    input  o, busy, toggles
  );

  modport slave (
    input  i, mask, force_en,
    input  force_val, cnt_clr,
    output o, busy, toggles
  );
endinterface

// File: rtl/nand_n_filt.sv
// N-input NAND/AND service cell
// synchroniser, glitch filter, force override, toggle count
module nand_n_filt #(
  parameter int   WIDTH       = 4,
  parameter int   INVERT      = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 3,
  parameter int   CNT_W       = 8,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic         CELCLK,
  input  logic         CELRST,
  input  logic         CELV,
  input  logic         CELG,
  input  logic         SUB,
  nand_n_filt_if.slave bus
);

  localparam int CW =
    (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  localparam logic [0:0] STABLE = 1'b0;
  localparam logic [0:0] PEND   = 1'b1;

  wire unused_pins = &{1'b0, CELV, CELG, SUB};

  logic [WIDTH-1:0] isync;
  logic             all_hi;
  logic             raw;

  logic [0:0]       st_q, st_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             o_q, o_n;
  logic [CNT_W-1:0] tog_q, tog_n;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign isync = bus.i;
  end else begin : g_sync
    logic [WIDTH-1:0] sq [SYNC_STAGES];

    // shift the asynchronous inputs through the synchroniser chain
    always_ff @(posedge CELCLK) begin
      if (CELRST) begin
        for (int k = 0; k < SYNC_STAGES; k++)
          sq[k] <= '0;
      end else begin
        sq[0] <= bus.i;
        for (int k = 1; k < SYNC_STAGES; k++)
          sq[k] <= sq[k-1];
      end
    end

    assign isync = sq[SYNC_STAGES-1];
  end

  assign all_hi = &(isync | ~bus.mask);
  assign raw    = (INVERT != 0) ? ~all_hi : all_hi;

  // filter FSM next state; force overrides the filter
  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    o_n   = o_q;
    if (bus.force_en) begin
      o_n   = bus.force_val;
      st_n  = STABLE;
      cnt_n = '0;
    end else begin
      case (st_q)
        STABLE: begin
          if (raw != o_q) begin
            if (DEBOUNCE == 1) begin
              o_n = raw;
            end else begin
              cnt_n = CW'(1);
              st_n  = PEND;
            end
          end
        end
        PEND: begin
          if (raw == o_q) begin
            cnt_n = '0;
            st_n  = STABLE;
          end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            o_n   = raw;
            cnt_n = '0;
            st_n  = STABLE;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_n = '0;
          st_n  = STABLE;
        end
      endcase
    end
  end

  // saturating count of output edges; clear wins
  always_comb begin
    tog_n = tog_q;
    if (o_n != o_q && tog_q != '1)
      tog_n = tog_q + CNT_W'(1);
    if (bus.cnt_clr)
      tog_n = '0;
  end

  // state registers with synchronous reset
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      st_q  <= STABLE;
      cnt_q <= '0;
      o_q   <= RST_VAL;
      tog_q <= '0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
      o_q   <= o_n;
      tog_q <= tog_n;
    end
  end

  assign bus.o       = o_q;
  assign bus.busy    = (st_q == PEND);
  assign bus.toggles = tog_q;

endmodule

// File: tb/tb_nand_n_filt.sv
// directed bench for nand_n_filt
// dut1: NAND default params, dut2: AND, CNT_W=2, no sync
module tb_nand_n_filt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic celv = 1'b1;
  logic celg = 1'b0;
  logic sub = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  nand_n_filt_if #(.WIDTH(4), .CNT_W(8)) b1 ();
  nand_n_filt_if #(.WIDTH(4), .CNT_W(2)) b2 ();

  nand_n_filt #(
    .WIDTH(4), .INVERT(1), .SYNC_STAGES(2),
    .DEBOUNCE(3), .CNT_W(8), .RST_VAL(1'b1)
  ) dut1 (
    .CELCLK(clk), .CELRST(rst), .CELV(celv),
    .CELG(celg), .SUB(sub), .bus(b1)
  );

  nand_n_filt #(
    .WIDTH(4), .INVERT(0), .SYNC_STAGES(0),
    .DEBOUNCE(1), .CNT_W(2), .RST_VAL(1'b1)
  ) dut2 (
    .CELCLK(clk), .CELRST(rst), .CELV(celv),
    .CELG(celg), .SUB(sub), .bus(b2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b1.i = 4'h0; b1.mask = 4'hF;
    b1.force_en = 0; b1.force_val = 0;
    b1.cnt_clr = 0;
    b2.i = 4'hF; b2.mask = 4'hF;
    b2.force_en = 0; b2.force_val = 0;
    b2.cnt_clr = 0;
    step(2);
    total_cnt++;
    if (b1.o !== 1'b1)
      $display("FAIL rst_o got %b exp 1", b1.o);
    else pass_cnt++;
    total_cnt++;
    if (b1.busy !== 1'b0)
      $display("FAIL rst_busy got %b exp 0", b1.busy);
    else pass_cnt++;
    total_cnt++;
    if (b1.toggles !== 8'd0)
      $display("FAIL rst_tog got %0d exp 0",
               b1.toggles);
    else pass_cnt++;
    total_cnt++;
    if (b2.o !== 1'b1)
      $display("FAIL rst_o2 got %b exp 1", b2.o);
    else pass_cnt++;
    rst = 1'b0;
    step(1);
  endtask

  // o new after the 5th edge following the drive,
  // i.e. in the 6th cycle counting the drive cycle
  task automatic test_debounce;
    int lat;
    int bz;
    lat = 0;
    bz = 0;
    b1.i = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (b1.busy === 1'b1) bz++;
      if (lat == 0 && b1.o === 1'b0) lat = k;
    end
    total_cnt++;
    if (lat != 5)
      $display("FAIL deb_lat got %0d exp 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (bz != 2)
      $display("FAIL deb_busy got %0d exp 2", bz);
    else pass_cnt++;
    total_cnt++;
    if (b1.toggles !== 8'd1)
      $display("FAIL deb_tog got %0d exp 1",
               b1.toggles);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    int bz;
    int low;
    b1.i = 4'h0;
    step(8);
    total_cnt++;
    if (b1.o !== 1'b1 || b1.toggles !== 8'd2)
      $display("FAIL gl_pre got o=%b t=%0d exp 1/2",
               b1.o, b1.toggles);
    else pass_cnt++;
    bz = 0;
    low = 0;
    b1.i = 4'hF;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (k == 1) b1.i = 4'h0;
      if (b1.busy === 1'b1) bz++;
      if (b1.o !== 1'b1) low++;
    end
    total_cnt++;
    if (low != 0)
      $display("FAIL gl_o got %0d low cycles exp 0",
               low);
    else pass_cnt++;
    total_cnt++;
    if (bz != 2)
      $display("FAIL gl_busy got %0d exp 2", bz);
    else pass_cnt++;
    total_cnt++;
    if (b1.toggles !== 8'd2)
      $display("FAIL gl_tog got %0d exp 2",
               b1.toggles);
    else pass_cnt++;
  endtask

  task automatic test_mask;
    b1.mask = 4'b0011;
    b1.i = 4'b0011;
    step(8);
    total_cnt++;
    if (b1.o !== 1'b0)
      $display("FAIL mask_0011 got %b exp 0", b1.o);
    else pass_cnt++;
    b1.mask = 4'b0000;
    step(8);
    total_cnt++;
    if (b1.o !== 1'b0 || b1.busy !== 1'b0)
      $display("FAIL mask_0 got o=%b b=%b exp 0/0",
               b1.o, b1.busy);
    else pass_cnt++;
    b1.mask = 4'hF;
    b1.i = 4'h0;
    step(8);
    total_cnt++;
    if (b1.o !== 1'b1 || b1.toggles !== 8'd4)
      $display("FAIL mask_rest got o=%b t=%0d exp 1/4",
               b1.o, b1.toggles);
    else pass_cnt++;
  endtask

  task automatic test_force;
    b1.force_val = 1'b0;
    b1.force_en = 1'b1;
    step(1);
    total_cnt++;
    if (b1.o !== 1'b0 || b1.toggles !== 8'd5)
      $display("FAIL frc_on got o=%b t=%0d exp 0/5",
               b1.o, b1.toggles);
    else pass_cnt++;
    b1.force_en = 1'b0;
    step(2);
    total_cnt++;
    if (b1.o !== 1'b0 || b1.busy !== 1'b1)
      $display("FAIL frc_pend got o=%b b=%b exp 0/1",
               b1.o, b1.busy);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (b1.o !== 1'b1 || b1.toggles !== 8'd6)
      $display("FAIL frc_rel got o=%b t=%0d exp 1/6",
               b1.o, b1.toggles);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pend;
    b1.i = 4'hF;
    step(3);
    total_cnt++;
    if (b1.busy !== 1'b1)
      $display("FAIL rmp_busy got %b exp 1", b1.busy);
    else pass_cnt++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    b1.i = 4'h0;
    total_cnt++;
    if (b1.o !== 1'b1 || b1.busy !== 1'b0 ||
        b1.toggles !== 8'd0)
      $display("FAIL rmp got o=%b b=%b t=%0d exp 1/0/0",
               b1.o, b1.busy, b1.toggles);
    else pass_cnt++;
    step(6);
    total_cnt++;
    if (b1.o !== 1'b1 || b1.toggles !== 8'd0)
      $display("FAIL rmp_after got o=%b t=%0d exp 1/0",
               b1.o, b1.toggles);
    else pass_cnt++;
  endtask

  task automatic test_counter;
    logic [1:0] exp_t [5];
    logic [3:0] vec [5];
    exp_t = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    vec = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
    for (int k = 0; k < 5; k++) begin
      b2.i = vec[k];
      step(1);
      total_cnt++;
      if (b2.toggles !== exp_t[k] ||
          b2.o !== vec[k][0])
        $display("FAIL cnt_%0d got t=%0d o=%b exp %0d/%b",
                 k, b2.toggles, b2.o,
                 exp_t[k], vec[k][0]);
      else pass_cnt++;
    end
    b2.i = 4'hF;
    b2.cnt_clr = 1'b1;
    step(1);
    b2.cnt_clr = 1'b0;
    total_cnt++;
    if (b2.toggles !== 2'd0 || b2.o !== 1'b1)
      $display("FAIL cnt_clr got t=%0d o=%b exp 0/1",
               b2.toggles, b2.o);
    else pass_cnt++;
    b2.mask = 4'h0;
    b2.i = 4'h0;
    step(2);
    total_cnt++;
    if (b2.o !== 1'b1 || b2.toggles !== 2'd0)
      $display("FAIL and_mask0 got o=%b t=%0d exp 1/0",
               b2.o, b2.toggles);
    else pass_cnt++;
    b2.mask = 4'b0011;
    b2.i = 4'b0001;
    step(1);
    total_cnt++;
    if (b2.o !== 1'b0 || b2.toggles !== 2'd1)
      $display("FAIL and_mask got o=%b t=%0d exp 0/1",
               b2.o, b2.toggles);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_mask();
    test_force();
    test_reset_mid_pend();
    test_counter();
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp done");
    $fatal(1);
  end

endmodule
